// File: rtl/pipe_divider.sv
// Multi-cycle radix-2 restoring divider with IDLE/CALC/DONE control and pipeline flush.
// Build option PIPE_DIVIDER_SIGNED_EN adds signed (div) support; without it every divide is unsigned.
module pipe_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              cancel_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_zero_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] rem_reg;
    logic [DATA_W-1:0] quo_reg;
    logic [DATA_W-1:0] dvs_reg;
    logic              done_reg;

    logic              accept;
    logic [DATA_W-1:0] dividend_mag;
    logic [DATA_W-1:0] divisor_mag;
    logic [DATA_W:0]   shifted;
    logic              fits;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] quo_final;
    logic [DATA_W-1:0] rem_final;

    assign accept = (state_reg == IDLE) && start_i && !cancel_i;

`ifdef PIPE_DIVIDER_SIGNED_EN
    logic dividend_neg;
    logic divisor_neg;
    logic neg_q_reg;
    logic neg_r_reg;

    assign dividend_neg = signed_i && dividend_i[DATA_W-1];
    assign divisor_neg  = signed_i && divisor_i[DATA_W-1];
    assign dividend_mag = dividend_neg ? (-dividend_i) : dividend_i;
    assign divisor_mag  = divisor_neg  ? (-divisor_i)  : divisor_i;

    // Quotient sign follows the operand signs; remainder follows the dividend.
    assign quo_final = neg_q_reg ? (-quo_next) : quo_next;
    assign rem_final = neg_r_reg ? (-rem_next) : rem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= dividend_neg ^ divisor_neg;
            neg_r_reg <= dividend_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign dividend_mag  = dividend_i;
    assign divisor_mag   = divisor_i;
    assign quo_final     = quo_next;
    assign rem_final     = rem_next;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted  = {rem_reg, quo_reg[DATA_W-1]};
    assign fits     = shifted >= {1'b0, dvs_reg};
    assign rem_next = fits ? (shifted[DATA_W-1:0] - dvs_reg) : shifted[DATA_W-1:0];
    assign quo_next = {quo_reg[DATA_W-2:0], fits};

    assign stall_o = (state_reg == CALC) || accept;
    assign done_o  = done_reg && !cancel_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            done_reg    <= 1'b0;
            busy_o      <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        if (divisor_i == '0) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            quotient_o  <= '1;
                            remainder_o <= dividend_i;
                            div_zero_o  <= 1'b1;
                        end else begin
                            state_reg  <= CALC;
                            busy_o     <= 1'b1;
                            count_reg  <= '0;
                            rem_reg    <= '0;
                            quo_reg    <= dividend_mag;
                            dvs_reg    <= divisor_mag;
                            div_zero_o <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        rem_reg   <= rem_next;
                        quo_reg   <= quo_next;
                        count_reg <= count_reg + 1'b1;
                        // Last iteration writes the sign-corrected result straight to the outputs.
                        if (count_reg == CNT_W'(DATA_W - 1)) begin
                            state_reg   <= DONE;
                            busy_o      <= 1'b0;
                            done_reg    <= 1'b1;
                            quotient_o  <= quo_final;
                            remainder_o <= rem_final;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_divider.sv
// Scoreboard bench for pipe_divider: stimulus pushes expected results, a monitor pops them on done_o.
// Reference results come from plain integer division; signed cases follow PIPE_DIVIDER_SIGNED_EN.
module tb_pipe_divider;

    localparam int W = 32;
`ifdef PIPE_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic         signed_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         cancel_i = 1'b0;
    logic         busy_o;
    logic         stall_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_zero_o;

    pipe_divider #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sd, qq, rr;
        e.cyc = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            qq = sa / sd;
            rr = sa % sd;
            e.q = qq[W-1:0]; e.r = rr[W-1:0]; e.dz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done_o must match the oldest outstanding expectation, on its cycle.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", W'(cyc), W'(mon_e.cyc));
                check("quotient", quotient_o, mon_e.q);
                check("remainder", remainder_o, mon_e.r);
                check("div_zero", W'(div_zero_o), W'(mon_e.dz));
                $display("done: q=%h r=%h dz=%0d at cycle %0d", quotient_o, remainder_o, div_zero_o, cyc);
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done_o, expected one at cycle %0d", mon_e.cyc);
        end
    end

    // Issue one divide at a fresh IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noisy, input bit chk_stall);
        exp_t e;
        int lat;
        e = model(s, a, b);
        lat = (b == '0) ? 1 : W + 1;
        e.cyc = cyc + lat;
        sb.push_back(e);
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        if (chk_stall) begin
            #1 check("stall_start", W'(stall_o), W'(1'b1));
        end
        for (int i = 0; i <= lat; i++) begin
            @(posedge clk); #1;
            if (noisy && i < lat) begin
                start_i = 1'b1; signed_i = 1'($urandom_range(0, 1));
                dividend_i = $urandom; divisor_i = $urandom;
            end else begin
                start_i = 1'b0;
            end
            if (chk_stall) begin
                #1;
                check("stall_calc", W'(stall_o), W'(b != '0 && i < W));
                check("busy_calc", W'(busy_o), W'(b != '0 && i < W));
            end
        end
        start_i = 1'b0;
        last = e;
        $display("issued: s=%0d %h / %h -> q=%h r=%h dz=%0d", s, a, b, e.q, e.r, e.dz);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_q"}, quotient_o, last.q);
        check({tag, "_r"}, remainder_o, last.r);
        check({tag, "_dz"}, W'(div_zero_o), W'(last.dz));
    endtask

    logic         rs;
    logic [W-1:0] ra, rb;

    initial begin
        last = '{q: '0, r: '0, dz: 1'b0, cyc: 0};
        idle(3);
        check("reset_done", W'(done_o), '0);
        check("reset_busy", W'(busy_o), '0);
        check("reset_stall", W'(stall_o), '0);
        check_held("reset");

        rst = 1'b1;
        idle(2);
        check("release_busy", W'(busy_o), '0);

        issue(1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        issue(1'b0, 32'h12345678, 32'd0, 1'b0, 1'b0);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(1'b0, 32'd1000, 32'd33, 1'b0, 1'b0);

        // Cancel in the 10th CALC cycle: no done, results held.
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        last.dz = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        #1;
        check("cancel_busy", W'(busy_o), '0);
        check("cancel_stall", W'(stall_o), '0);
        check_held("cancel_held");
        idle(W + 4);
        check_held("cancel_late");
        $display("cancel: 100/7 aborted at CALC cycle 10");
        issue(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

        // Start and cancel together in IDLE: nothing starts.
        start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
        #1 check("cancel_start_stall", W'(stall_o), '0);
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        #1 check("cancel_start_busy", W'(busy_o), '0);
        idle(W + 3);
        check_held("cancel_start_held");
        $display("cancel+start in IDLE: ignored");

        for (int k = 0; k < 50; k++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 6))
                0: rb = '0;
                1: rb = 32'd1;
                2: rb = 32'hFFFFFFFF;
                3: rb = W'($urandom_range(1, 255));
                4: rb = ra >> $urandom_range(1, 31);
                5: rb = -W'($urandom_range(1, 1000));
                default: rb = $urandom;
            endcase
            issue(rs, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(0, 2));
        end

        // Asynchronous reset in the 5th CALC cycle discards the divide.
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        rst = 1'b0;
        #1;
        sb.delete();
        last = '{q: '0, r: '0, dz: 1'b0, cyc: 0};
        check("midreset_done", W'(done_o), '0);
        check("midreset_busy", W'(busy_o), '0);
        check_held("midreset");
        idle(2);
        rst = 1'b1;
        idle(W + 5);
        check("post_reset_busy", W'(busy_o), '0);
        check_held("post_reset");
        $display("reset: 100/7 discarded at CALC cycle 5");
        issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);

        idle(5);
        check("scoreboard_empty", W'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_divider.md
PIPE_DIVIDER -- requirements
Module: pipe_divider

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits; the legal range is 8 to 64.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 Port start_i  input  1  request to start a divide; sampled only in IDLE.
REQ-005 Port signed_i  input  1  1 selects a signed (div) operation, 0 selects unsigned (divu); sampled with start_i.
REQ-006 Port dividend_i  input  DATA_W  dividend; sampled with start_i.
REQ-007 Port divisor_i  input  DATA_W  divisor; sampled with start_i.
REQ-008 Port cancel_i  input  1  pipeline flush; aborts any operation in progress.
REQ-009 Port busy_o  output  1  high while in CALC.
REQ-010 Port stall_o  output  1  combinational request to freeze the pipeline front end.
REQ-011 Port done_o  output  1  one-cycle pulse that marks a valid result.
REQ-012 Port quotient_o  output  DATA_W  quotient, destined for LO.
REQ-013 Port remainder_o  output  DATA_W  remainder, destined for HI.
REQ-014 Port div_zero_o  output  1  the completed operation had a zero divisor.

Function
REQ-015 The FSM has three states: IDLE, CALC and DONE.
REQ-016 IDLE->CALC when start_i=1, cancel_i=0 and divisor_i is nonzero; the operands, their signs and signed_i are latched on that edge.
REQ-017 IDLE->DONE when start_i=1, cancel_i=0 and divisor_i=0.
- On this path quotient_o = all ones, remainder_o = dividend_i, div_zero_o = 1.
REQ-018 CALC runs a radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, for exactly DATA_W cycles, tracked by an internal counter; after the last iteration the state goes to DONE.
REQ-019 DONE lasts one cycle, with done_o=1 and the results valid, then returns to IDLE; a new start is accepted no earlier than the following IDLE cycle.
REQ-020 Latency from the start edge to done_o is DATA_W+1 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-021 For signed operations:
- quotient = magnitude quotient, negated when the operand signs differ;
- remainder = magnitude remainder, carrying the dividend's sign;
- all arithmetic wraps modulo 2^DATA_W.
REQ-022 Signed most-negative / -1 yields quotient = most-negative value, remainder = 0, div_zero_o = 0.
REQ-023 start_i is ignored in CALC and in DONE.
REQ-024 cancel_i=1 in CALC or DONE forces IDLE on the next edge and suppresses done_o.
- quotient_o, remainder_o and div_zero_o keep their previous values.
REQ-025 When cancel_i and start_i are both 1 in IDLE, cancel wins and nothing starts.
REQ-026 stall_o = (state==CALC) OR (state==IDLE AND start_i AND NOT cancel_i).
REQ-027 quotient_o, remainder_o and div_zero_o are registered and hold until the next DONE.
REQ-028 div_zero_o is cleared on every accepted start.

Reset
REQ-029 When rst=0, asynchronously: state=IDLE, counter=0, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_zero_o=0.
REQ-030 A reset mid-CALC discards the operation and no done_o is ever issued for it.
REQ-031 Release of rst takes effect on the first rising clk edge after deassertion; no operation starts on that edge unless start_i=1.

Configuration
REQ-032 The macro PIPE_DIVIDER_SIGNED_EN controls signed support.
- Defined: signed_i behaves as specified in REQ-005 and REQ-021.
- Undefined: signed_i is ignored, every operation is unsigned, and the sign-correction logic is absent.

Verification
REQ-033 The bench covers the following directed scenarios (DATA_W=32, SIGNED_EN defined):
- unsigned 100/7 -> done_o exactly 33 cycles after start; quotient_o=14, remainder_o=2; stall_o high from the start cycle through the last CALC cycle.
- signed 0xFFFFFFF9 (-7) / 2 -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF.
- 0x12345678 / 0 -> done_o next cycle; quotient_o=0xFFFFFFFF, remainder_o=0x12345678, div_zero_o=1.
- signed 0x80000000 / 0xFFFFFFFF -> quotient_o=0x80000000, remainder_o=0, div_zero_o=0.
- start 100/7, cancel_i at CALC cycle 10 -> IDLE next cycle; no done_o; previous results held; a follow-up 9/3 gives 3 r 0.
- rst low at CALC cycle 5 -> all outputs 0 immediately; no done_o after release.
